// File: rtl/cla_nibble_sequencer.sv
// -----------------------------------------------------------------------------
// cla_nibble_sequencer
//
// Sequential W-bit adder/subtractor (W = 4*NIBBLES) built around a single 4-bit
// carry-lookahead adder that is reused once per nibble, least significant
// nibble first. The ripple between nibbles goes through a carry register, so a
// W-bit operation takes NIBBLES RUN cycles.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start_valid  request carries valid operands
//   start_ready  block accepts a request this cycle (IDLE and not in reset)
//   a, b         W-bit operands, sampled only on accept
//   cin          carry-in for add, sampled on accept, ignored for subtract
//   op_sub       0: a + b + cin, 1: a - b (a + ~b + 1), sampled on accept
//   sum          registered W-bit result
//   cout         carry out of bit W-1 (for subtract, 1 = no borrow)
//   ovf          two's-complement signed overflow of the W-bit operation
//   done_valid   sum/cout/ovf hold a fresh result
//   done_ready   consumer takes the result
//   busy         operation in flight (state is not IDLE)
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. start_ready depends only on state and rst, never on start_valid.
// Once done_valid rises, sum/cout/ovf stay stable until the edge where
// done_ready is also high.
// -----------------------------------------------------------------------------

// 4-bit carry-lookahead adder: every carry is computed directly from the
// generate/propagate terms, with no ripple through the nibble.
module Carry_Lookahead_Adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign carry = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;
endmodule

module cla_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    input  logic                 op_sub,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    // Nibble index width; kept at least 1 bit so NIBBLES=1 still has a k.
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [KW-1:0]  k;
    logic           carry_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;      // already inverted for subtract
    logic [W-1:0]   sum_reg;
    logic           cout_reg;
    logic           ovf_reg;
    logic           done_reg;

    logic [KW+1:0]  base;       // bit offset of the current nibble
    logic [3:0]     cla_a;
    logic [3:0]     cla_b;
    logic [3:0]     cla_sum;
    logic           cla_carry;

    assign base  = {k, 2'b00};
    assign cla_a = a_reg[base +: 4];
    assign cla_b = b_reg[base +: 4];

    Carry_Lookahead_Adder u_cla (
        .a     (cla_a),
        .b     (cla_b),
        .cin   (carry_reg),
        .sum   (cla_sum),
        .carry (cla_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_reg     <= a;
                        b_reg     <= op_sub ? ~b : b;
                        carry_reg <= op_sub ? 1'b1 : cin;
                        k         <= '0;
                        sum_reg   <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[base +: 4] <= cla_sum;
                    carry_reg          <= cla_carry;
                    k                  <= k + 1'b1;
                    if (k == LAST_K) begin
                        cout_reg <= cla_carry;
                        // Overflow: operands share a sign that the result lacks.
                        // cla_sum[3] is the new sum MSB written on this edge.
                        ovf_reg  <= (a_reg[W-1] == b_reg[W-1])
                                  & (cla_sum[3] != a_reg[W-1]);
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_reg <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state == IDLE) & ~rst;
    assign busy        = (state != IDLE) & ~rst;
    assign sum         = sum_reg;
    assign cout        = cout_reg;
    assign ovf         = ovf_reg;
    assign done_valid  = done_reg;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for cla_nibble_sequencer with NIBBLES=4 (16-bit operands).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cla_nibble_sequencer;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
    localparam int N_RAND  = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         done_valid;
    logic         done_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    cla_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .op_sub      (op_sub),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from plain integer arithmetic: returns {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                                input logic rcin, input logic rop);
        longint ua, ub, sa, sb, full, sres, lim;
        logic   c, o;
        logic [W-1:0] s;
        ua  = longint'(ra);
        ub  = longint'(rb);
        lim = longint'(1) << (W - 1);
        sa  = ra[W-1] ? ua - (lim * 2) : ua;
        sb  = rb[W-1] ? ub - (lim * 2) : ub;
        if (rop) begin
            full = ua - ub;
            c    = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub + longint'(rcin);
            c    = (full >= lim * 2);
            sres = sa + sb + longint'(rcin);
        end
        s = full[W-1:0];
        o = (sres >= lim) || (sres < -lim);
        return {o, c, s};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin, input logic top);
        int guard = 0;
        while (!start_ready && guard < 20) begin
            @(posedge clk); @(negedge clk);
            guard++;
        end
        chk("start_ready_before_accept", {31'd0, start_ready}, 32'd1);
        a = ta; b = tb; cin = tcin; op_sub = top;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        // Scramble inputs: the in-flight result must not depend on them.
        a = W'($urandom); b = W'($urandom);
        cin = 1'($urandom); op_sub = 1'($urandom);
    endtask

    // Counts edges after the accept edge until done_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done_valid && lat < 20) begin
            chk("busy_while_running", {31'd0, busy}, 32'd1);
            @(posedge clk); @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result();
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        chk("done_valid_drops", {31'd0, done_valid}, 32'd0);
        chk("idle_after_done", {31'd0, start_ready}, 32'd1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         op_sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    // ---------------- main sequence ----------------
    logic [W+1:0] exp_q[$];
    logic [W+1:0] e;
    logic [W-1:0] held_sum;
    int           lat;
    int           issued;
    int           completed;
    int           cyc;
    logic         fire_start;
    logic         fire_done;
    logic         seen_done;

    initial begin
        vecs[0] = '{16'h0001, 16'h00FF, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0003, 16'h0004, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        // Reset with a request pending: it must not be accepted.
        rst = 1'b1; start_valid = 1'b1; done_ready = 1'b0;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; op_sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_sum", {16'd0, sum}, 32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        chk("reset_done_valid", {31'd0, done_valid}, 32'd0);
        chk("reset_start_ready", {31'd0, start_ready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        start_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_reset_start_ready", {31'd0, start_ready}, 32'd1);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op_sub);
            wait_done(lat);
            chk($sformatf("vec%0d_latency", i), lat, NIBBLES);
            chk($sformatf("vec%0d_sum", i), {16'd0, sum}, {16'd0, vecs[i].sum});
            chk($sformatf("vec%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].cout});
            chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
            take_result();
            chk($sformatf("vec%0d_sum_kept_idle", i), {16'd0, sum}, {16'd0, vecs[i].sum});
        end

        // Backpressure in DONE with a competing request
        accept(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_done(lat);
        chk("bp_latency", lat, NIBBLES);
        held_sum = sum;
        chk("bp_sum", {16'd0, held_sum}, 32'h2345);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b1; op_sub = 1'b0;
        start_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("bp_sum_held", {16'd0, sum}, 32'h2345);
            chk("bp_cout_held", {31'd0, cout}, 32'd0);
            chk("bp_ovf_held", {31'd0, ovf}, 32'd0);
            chk("bp_start_ready_low", {31'd0, start_ready}, 32'd0);
            chk("bp_done_valid_high", {31'd0, done_valid}, 32'd1);
        end
        done_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        done_ready = 1'b0;
        chk("bp_idle_start_ready", {31'd0, start_ready}, 32'd1);
        chk("bp_idle_done_valid", {31'd0, done_valid}, 32'd0);
        @(posedge clk); @(negedge clk);   // pending request accepted here
        start_valid = 1'b0;
        wait_done(lat);
        chk("bp_next_latency", lat, NIBBLES);
        chk("bp_next_sum", {16'd0, sum}, 32'h0001);
        chk("bp_next_cout", {31'd0, cout}, 32'd1);
        chk("bp_next_ovf", {31'd0, ovf}, 32'd0);
        take_result();

        // Reset after two nibbles of an operation
        accept(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum", {16'd0, sum}, 32'd0);
        chk("abort_done_valid", {31'd0, done_valid}, 32'd0);
        chk("abort_start_ready_in_reset", {31'd0, start_ready}, 32'd0);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (done_valid) seen_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);
        accept(16'h0001, 16'h00FF, 1'b0, 1'b0);
        wait_done(lat);
        chk("after_abort_latency", lat, NIBBLES);
        chk("after_abort_sum", {16'd0, sum}, 32'h0100);
        chk("after_abort_cout", {31'd0, cout}, 32'd0);
        chk("after_abort_ovf", {31'd0, ovf}, 32'd0);
        take_result();

        // Randomized stream against the reference model
        issued = 0; completed = 0; cyc = 0;
        start_valid = 1'b0; done_ready = 1'b0;
        while (completed < N_RAND && cyc < 40000) begin
            if (!start_valid && issued < N_RAND && $urandom_range(0, 3) != 0) begin
                start_valid = 1'b1;
                a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom); op_sub = 1'($urandom);
            end
            done_ready = ($urandom_range(0, 2) != 0);
            fire_start = start_valid && start_ready;
            fire_done  = done_valid && done_ready;
            if (fire_done) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_result", {14'd0, ovf, cout, sum}, {14'd0, e});
                end
                completed++;
            end
            if (fire_start) begin
                exp_q.push_back(ref_model(a, b, cin, op_sub));
                issued++;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (fire_start) begin
                start_valid = 1'b0;
                a = W'($urandom); b = W'($urandom);
            end
        end
        done_ready = 1'b0;
        chk("rand_all_completed", completed, N_RAND);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
